pll_reset_seq: RTL and testbench

Reset and lock sequencer for the board PLL. Runs on the raw reference clock, drives the PLL reset, qualifies the asynchronous lock indication and releases the downstream domain resets in a fixed order. Re-sequences the PLL on lock loss. Sits between the board clock/reset pins and the PLL wrapper plus the per-domain reset synchronizers.

---
 rtl/pll_reset_seq.sv | 199 +++++++++++++++++++
 tb/tb_pll_reset_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset, lock qualification and ordered domain reset release
// Define PLL_SEQ_WATCHDOG_EN to enable the WAIT_LOCK watchdog, retry limit and FAULT state.
module pll_reset_seq #(
  parameter int PWR_CYC   = 16,
  parameter int LOCK_CYC  = 1024,
  parameter int STAGES    = 5,
  parameter int STAGE_GAP = 64,
  parameter int LOCK_TMO  = 50000,
  parameter int RETRY_MAX = 4
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic              lock_lost,
  output logic              fault,
  output logic [2:0]        retries
);

  localparam int PW = $clog2(PWR_CYC + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic              lk_meta;
  logic              lk;
  logic [2:0]        state;
  logic [PW-1:0]     pcnt;
  logic [LW-1:0]     lcnt;
  logic [GW-1:0]     gcnt;
  logic [STAGES-1:0] rel_next;
  logic [2:0]        retries_next;
  logic              to_fault;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  assign rel_next     = rst_out << 1;
  assign retries_next = (retries == 3'd7) ? 3'd7 : retries + 3'd1;

`ifdef PLL_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(LOCK_TMO + 1);

  logic [TW-1:0] wcnt;
  logic          fault_q;
  logic          wd_expired;

  assign to_fault   = (int'(retries_next) >= RETRY_MAX);
  assign wd_expired = (wcnt == TW'(LOCK_TMO - 1));
  assign fault      = fault_q;
`else
  logic unused_cfg;

  assign to_fault   = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = ^{LOCK_TMO[0], RETRY_MAX[0]};
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= S_PLL_RST;
      pcnt      <= '0;
      lcnt      <= '0;
      gcnt      <= '0;
      pll_rst   <= 1'b1;
      rst_out   <= '1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retries   <= 3'd0;
`ifdef PLL_SEQ_WATCHDOG_EN
      wcnt      <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      lock_lost <= 1'b0;
      if ((state == S_RELEASE || state == S_RUN) && !lk) begin
        // Lock dropped after qualification: every domain goes back into reset at once.
        lock_lost <= 1'b1;
        retries   <= retries_next;
        pll_rst   <= 1'b1;
        rst_out   <= '1;
        ready     <= 1'b0;
        pcnt      <= '0;
        lcnt      <= '0;
        gcnt      <= '0;
        state     <= to_fault ? S_FAULT : S_PLL_RST;
`ifdef PLL_SEQ_WATCHDOG_EN
        wcnt      <= '0;
        fault_q   <= to_fault;
`endif
      end else begin
        case (state)
          S_PLL_RST: begin
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
            if (pcnt == PW'(PWR_CYC - 1)) begin
              state   <= S_WAIT_LOCK;
              pcnt    <= '0;
              pll_rst <= 1'b0;
`ifdef PLL_SEQ_WATCHDOG_EN
              wcnt    <= '0;
`endif
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end

          S_WAIT_LOCK: begin
            // A lock seen on the expiry cycle still wins over the watchdog.
            if (lk) begin
              state <= S_STABLE;
              lcnt  <= LW'(1);
            end
`ifdef PLL_SEQ_WATCHDOG_EN
            else if (wd_expired) begin
              retries <= retries_next;
              pll_rst <= 1'b1;
              wcnt    <= '0;
              pcnt    <= '0;
              state   <= to_fault ? S_FAULT : S_PLL_RST;
              fault_q <= to_fault;
            end else begin
              wcnt <= wcnt + TW'(1);
            end
`endif
          end

          S_STABLE: begin
            // Watchdog is deliberately kept across a fall back to WAIT_LOCK.
            if (!lk) begin
              state <= S_WAIT_LOCK;
              lcnt  <= '0;
            end else if (lcnt >= LW'(LOCK_CYC - 1)) begin
              lcnt    <= '0;
              gcnt    <= '0;
              rst_out <= ~STAGES'(1);
              if (STAGES == 1) begin
                state <= S_RUN;
                ready <= 1'b1;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              lcnt <= lcnt + LW'(1);
            end
          end

          S_RELEASE: begin
            if (gcnt == GW'(STAGE_GAP - 1)) begin
              gcnt    <= '0;
              rst_out <= rel_next;
              if (rel_next == '0) begin
                state <= S_RUN;
                ready <= 1'b1;
              end
            end else begin
              gcnt <= gcnt + GW'(1);
            end
          end

          S_RUN: begin
            ready <= 1'b1;
          end

          S_FAULT: begin
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
          end

          default: begin
            state   <= S_PLL_RST;
            pcnt    <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

  localparam int PWR_CYC   = 4;
  localparam int LOCK_CYC  = 8;
  localparam int STAGES    = 3;
  localparam int STAGE_GAP = 2;
  localparam int LOCK_TMO  = 100;
  localparam int RETRY_MAX = 2;
`ifdef PLL_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic              clkin = 1'b0;
  logic              rst = 1'b1;
  logic              pll_locked = 1'b0;
  logic              pll_rst;
  logic [STAGES-1:0] rst_out;
  logic              ready;
  logic              lock_lost;
  logic              fault;
  logic [2:0]        retries;

  always #5 clkin = ~clkin;

  pll_reset_seq #(
    .PWR_CYC(PWR_CYC), .LOCK_CYC(LOCK_CYC), .STAGES(STAGES),
    .STAGE_GAP(STAGE_GAP), .LOCK_TMO(LOCK_TMO), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clkin(clkin), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_out(rst_out), .ready(ready), .lock_lost(lock_lost), .fault(fault),
    .retries(retries)
  );

  int checks = 0;
  int errors = 0;

  // Vector layout: {pll_rst, rst_out[2:0], ready, lock_lost, fault, retries[2:0]}
  localparam logic [9:0] RST_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 3'd0};

  typedef struct {
    int         n;
    bit         pl;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Reference model: phases with timestamps, outputs derived arithmetically.
  typedef enum int {M_RST, M_WAIT, M_QUAL, M_GO, M_FAULT} mphase_t;
  mphase_t m_phase;
  int      m_n, m_start, m_wd, m_streak, m_retries;
  bit      m_s1, m_s2, m_ll;

  function automatic void model_reset();
    m_phase = M_RST; m_n = 0; m_start = 0; m_wd = 0; m_streak = 0;
    m_retries = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_ll = 1'b0;
  endfunction

  function automatic void model_fail(bit loss);
    m_retries = (m_retries < 7) ? m_retries + 1 : 7;
    m_ll = loss;
    if (WD_EN && m_retries >= RETRY_MAX) m_phase = M_FAULT;
    else begin
      m_phase = M_RST;
      m_start = m_n;
    end
  endfunction

  function automatic void model_edge(bit pl);
    bit lk_now;
    lk_now = m_s2;
    m_s2 = m_s1;
    m_s1 = pl;
    m_n++;
    m_ll = 1'b0;
    case (m_phase)
      M_RST: if (m_n - m_start == PWR_CYC) begin m_phase = M_WAIT; m_wd = 0; end
      M_WAIT:
        if (lk_now) begin m_phase = M_QUAL; m_streak = 1; end
        else begin
          m_wd++;
          if (WD_EN && m_wd == LOCK_TMO) model_fail(1'b0);
        end
      M_QUAL:
        if (!lk_now) m_phase = M_WAIT;
        else begin
          m_streak++;
          if (m_streak == LOCK_CYC) begin m_phase = M_GO; m_start = m_n; end
        end
      M_GO: if (!lk_now) model_fail(1'b1);
      default: ;
    endcase
  endfunction

  function automatic logic [9:0] model_out();
    int k;
    logic [STAGES-1:0] ro;
    k = 0;
    if (m_phase == M_GO) begin
      k = (m_n - m_start) / STAGE_GAP + 1;
      if (k > STAGES) k = STAGES;
    end
    ro = '1;
    ro = ro << k;
    return {(m_phase == M_RST || m_phase == M_FAULT), ro, (k == STAGES), m_ll,
            (m_phase == M_FAULT), 3'(m_retries)};
  endfunction

  function automatic logic [9:0] ov(bit p, logic [2:0] ro, bit rdy, bit ll, bit flt, logic [2:0] rt);
    return {p, ro, rdy, ll, flt, rt};
  endfunction

  task automatic check_vec(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {pll_rst, rst_out, ready, lock_lost, fault, retries};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: {pll_rst,rst_out,ready,lock_lost,fault,retries} got %b want %b",
               name, m_n, act, exp);
    end
  endtask

  task automatic step(input bit pl);
    pll_locked = pl;
    @(posedge clkin);
    model_edge(pl);
    @(negedge clkin);
    check_vec("model", model_out());
  endtask

  task automatic run(input int n, input bit pl);
    for (int i = 0; i < n; i++) step(pl);
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic apply_reset(input bit pl);
    pll_locked = pl;
    rst = 1'b1;
    #1;
    check_vec("rst_async", RST_VEC);
    model_reset();
    @(posedge clkin);
    @(negedge clkin);
    check_vec("rst_held", RST_VEC);
    rst = 1'b0;
  endtask

  task automatic add(input int n, input bit pl, input logic [9:0] e);
    vec_t v;
    v.n = n; v.pl = pl; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    bit rpl;
    int rlen;
    int cyc;

    // Clean start, lock loss in RUN, re-lock.
    add(3, 1'b0, ov(1, 3'b111, 0, 0, 0, 0));
    add(1, 1'b0, ov(0, 3'b111, 0, 0, 0, 0));
    add(2, 1'b0, ov(0, 3'b111, 0, 0, 0, 0));
    add(9, 1'b1, ov(0, 3'b111, 0, 0, 0, 0));
    add(1, 1'b1, ov(0, 3'b110, 0, 0, 0, 0));
    add(1, 1'b1, ov(0, 3'b110, 0, 0, 0, 0));
    add(1, 1'b1, ov(0, 3'b100, 0, 0, 0, 0));
    add(1, 1'b1, ov(0, 3'b100, 0, 0, 0, 0));
    add(1, 1'b1, ov(0, 3'b000, 1, 0, 0, 0));
    add(5, 1'b1, ov(0, 3'b000, 1, 0, 0, 0));
    add(2, 1'b0, ov(0, 3'b000, 1, 0, 0, 0));
    add(1, 1'b0, ov(1, 3'b111, 0, 1, 0, 1));
    add(1, 1'b0, ov(1, 3'b111, 0, 0, 0, 1));
    add(2, 1'b0, ov(1, 3'b111, 0, 0, 0, 1));
    add(1, 1'b0, ov(0, 3'b111, 0, 0, 0, 1));
    add(9, 1'b1, ov(0, 3'b111, 0, 0, 0, 1));
    add(1, 1'b1, ov(0, 3'b110, 0, 0, 0, 1));
    add(4, 1'b1, ov(0, 3'b000, 1, 0, 0, 1));

    @(negedge clkin);
    apply_reset(1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].n, tbl[i].pl);
      check_vec($sformatf("seq_tbl[%0d]", i), tbl[i].exp);
    end

    // Glitchy lock: one low sample restarts qualification.
    apply_reset(1'b0);
    run(4, 1'b0);
    check_vec("glitch_wait", ov(0, 3'b111, 0, 0, 0, 0));
    run(5, 1'b1);
    run(1, 1'b0);
    run(4, 1'b1);
    check_vec("glitch_held_e14", ov(0, 3'b111, 0, 0, 0, 0));
    run(5, 1'b1);
    check_vec("glitch_held_e19", ov(0, 3'b111, 0, 0, 0, 0));
    run(1, 1'b1);
    check_vec("glitch_release", ov(0, 3'b110, 0, 0, 0, 0));
    run(4, 1'b1);
    check_vec("glitch_ready", ov(0, 3'b000, 1, 0, 0, 0));

    apply_reset(1'b0);
`ifdef PLL_SEQ_WATCHDOG_EN
    run(103, 1'b0);
    check_vec("wd_before_tmo1", ov(0, 3'b111, 0, 0, 0, 0));
    run(1, 1'b0);
    check_vec("wd_tmo1", ov(1, 3'b111, 0, 0, 0, 1));
    run(103, 1'b0);
    check_vec("wd_before_tmo2", ov(0, 3'b111, 0, 0, 0, 1));
    run(1, 1'b0);
    check_vec("wd_fault", ov(1, 3'b111, 0, 0, 1, 2));
    run(30, 1'b1);
    check_vec("wd_fault_sticky", ov(1, 3'b111, 0, 0, 1, 2));
`else
    run(1000, 1'b0);
    check_vec("nowd_wait", ov(0, 3'b111, 0, 0, 0, 0));
`endif

    // Async reset in RELEASE with rst_out=100, then a full restart.
    apply_reset(1'b1);
    run(14, 1'b1);
    check_vec("rel_100", ov(0, 3'b100, 0, 0, 0, 0));
    apply_reset(1'b1);
    run(15, 1'b1);
    check_vec("restart_100", ov(0, 3'b100, 0, 0, 0, 0));
    run(1, 1'b1);
    check_vec("restart_ready", ov(0, 3'b000, 1, 0, 0, 0));

    // Repeated lock losses: retries saturates (or FAULT with watchdog).
    apply_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      run(20, 1'b1);
      run(3, 1'b0);
    end
    if (WD_EN) check_vec("retry_limit", ov(1, 3'b111, 0, 0, 1, 2));
    else       check_vec("retry_sat", ov(1, 3'b111, 0, 1, 0, 7));

    // Randomized lock activity with occasional async resets.
    apply_reset(1'b0);
    cyc = 0;
    while (cyc < 3000) begin
      rpl  = 1'($urandom_range(0, 1));
      rlen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      if ($urandom_range(0, 39) == 0) apply_reset(rpl);
      run(rlen, rpl);
      cyc += rlen;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
